// File: rtl/jk_arb_pkg.sv
// Shared types and JK command encoding for the JK bank arbiter and its cell bank.
package jk_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        APPLY = 2'd2
    } arb_state_e;

    // Command encoding is {j, k}
    localparam logic [1:0] JK_HOLD = 2'b00;
    localparam logic [1:0] JK_CLR  = 2'b01;
    localparam logic [1:0] JK_SET  = 2'b10;
    localparam logic [1:0] JK_TGL  = 2'b11;

    function automatic logic jk_next(input logic [1:0] cmd, input logic cur);
        logic nxt;
        case (cmd)
            JK_CLR:  nxt = 1'b0;
            JK_SET:  nxt = 1'b1;
            JK_TGL:  nxt = ~cur;
            default: nxt = cur;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/jk_cell_bank.sv
// Bank of NBITS JK flip-flops with a single indexed write port and synchronous active-low clear.
module jk_cell_bank
    import jk_arb_pkg::*;
#(
    parameter int NBITS = 8,
    parameter int IDXW  = $clog2(NBITS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [IDXW-1:0]  widx,
    input  logic             j,
    input  logic             k,
    output logic [NBITS-1:0] q
);

    for (genvar gi = 0; gi < NBITS; gi++) begin : g_cell
        logic bit_reg;

        always_ff @(posedge clk) begin
            if (!reset) begin
                bit_reg <= 1'b0;
            end else if (we && (widx == IDXW'(gi))) begin
                bit_reg <= jk_next({j, k}, bit_reg);
            end
        end

        assign q[gi] = bit_reg;
    end

endmodule

// File: rtl/jk_bank_arbiter.sv
// Round-robin arbiter sequencing JK commands from NREQ requesters onto one shared JK bank.
// Optional burst ownership via extra lock input when JK_ARB_LOCK_EN is defined.
module jk_bank_arbiter
    import jk_arb_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int NBITS = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NREQ-1:0]               req,
    input  logic [NREQ-1:0]               j,
    input  logic [NREQ-1:0]               k,
    input  logic [NREQ*$clog2(NBITS)-1:0] idx,
`ifdef JK_ARB_LOCK_EN
    input  logic [NREQ-1:0]               lock,
`endif
    output logic [NREQ-1:0]               gnt,
    output logic [NREQ-1:0]               ack,
    output logic                          rdata,
    output logic                          err,
    output logic [NBITS-1:0]              q,
    output logic                          busy
);

    localparam int IDXW = $clog2(NBITS);
    localparam int PW   = $clog2(NREQ);

    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_GRANT = GRANT;
    localparam logic [1:0] ST_APPLY = APPLY;

    logic [1:0]      state_reg, state_next;
    logic [PW-1:0]   rr_ptr_reg, rr_ptr_next;
    logic [PW-1:0]   win_reg, win_next;
    logic            rdata_reg;
    logic            err_reg;

    logic [NREQ-1:0] win_onehot;
    logic [NREQ-1:0] others;
    logic [PW-1:0]   ptr_after;
    logic            lock_hold;

    logic [IDXW-1:0] sel_idx;
    logic            sel_j;
    logic            sel_k;
    logic            in_range;
    logic            cur_bit;
    logic            new_bit;
    logic            bank_we;

    // First set bit of mask at or above start, wrapping; caller guarantees mask is non-zero.
    function automatic logic [PW-1:0] rr_pick(input logic [NREQ-1:0] mask,
                                              input logic [PW-1:0]   start);
        logic [PW-1:0] pick;
        logic          found;
        int            c;
        pick  = '0;
        found = 1'b0;
        for (int off = 0; off < NREQ; off++) begin
            c = (int'(start) + off) % NREQ;
            if (!found && mask[c]) begin
                found = 1'b1;
                pick  = PW'(c);
            end
        end
        return pick;
    endfunction

    assign win_onehot = NREQ'(1) << win_reg;
    assign others     = req & ~win_onehot;
    assign ptr_after  = (win_reg == PW'(NREQ - 1)) ? '0 : win_reg + 1'b1;

`ifdef JK_ARB_LOCK_EN
    assign lock_hold = |(lock & req & win_onehot);
`else
    assign lock_hold = 1'b0;
`endif

    // Payload of the current winner; only consumed while in GRANT.
    always_comb begin
        sel_idx = '0;
        sel_j   = 1'b0;
        sel_k   = 1'b0;
        for (int r = 0; r < NREQ; r++) begin
            if (win_reg == PW'(r)) begin
                sel_idx = idx[r*IDXW +: IDXW];
                sel_j   = j[r];
                sel_k   = k[r];
            end
        end
    end

    assign in_range = (32'(sel_idx) < NBITS);

    always_comb begin
        cur_bit = 1'b0;
        for (int i = 0; i < NBITS; i++) begin
            if (sel_idx == IDXW'(i)) begin
                cur_bit = q[i];
            end
        end
    end

    assign new_bit = in_range ? jk_next({sel_j, sel_k}, cur_bit) : 1'b0;
    assign bank_we = (state_reg == ST_GRANT) && in_range;

    always_comb begin
        state_next  = state_reg;
        rr_ptr_next = rr_ptr_reg;
        win_next    = win_reg;
        case (state_reg)
            ST_IDLE: begin
                if (|req) begin
                    win_next   = rr_pick(req, rr_ptr_reg);
                    state_next = ST_GRANT;
                end
            end
            ST_GRANT: begin
                state_next = ST_APPLY;
            end
            ST_APPLY: begin
                if (lock_hold) begin
                    state_next = ST_GRANT;
                end else begin
                    rr_ptr_next = ptr_after;
                    if (|others) begin
                        win_next   = rr_pick(others, ptr_after);
                        state_next = ST_GRANT;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg  <= ST_IDLE;
            rr_ptr_reg <= '0;
            win_reg    <= '0;
            rdata_reg  <= 1'b0;
            err_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            rr_ptr_reg <= rr_ptr_next;
            win_reg    <= win_next;
            if (state_reg == ST_GRANT) begin
                rdata_reg <= new_bit;
                err_reg   <= ~in_range;
            end
        end
    end

    jk_cell_bank #(
        .NBITS (NBITS),
        .IDXW  (IDXW)
    ) u_bank (
        .clk   (clk),
        .reset (reset),
        .we    (bank_we),
        .widx  (sel_idx),
        .j     (sel_j),
        .k     (sel_k),
        .q     (q)
    );

    assign gnt   = (state_reg == ST_GRANT) ? win_onehot : '0;
    assign ack   = (state_reg == ST_APPLY) ? win_onehot : '0;
    assign rdata = (state_reg == ST_APPLY) && rdata_reg;
    assign err   = (state_reg == ST_APPLY) && err_reg;
    assign busy  = (state_reg != ST_IDLE);

endmodule
